// File: rtl/cpu_pkg.sv
// Shared RV64 core definitions: data widths, the canonical NOP and the fetch queue entry.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

    // Instruction fetch is word granular, so the low two address bits are forced to zero.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ring_buf.sv
// In-order fetch queue storage: entries are allocated at request time and filled by responses.
module fetch_ring_buf
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [ILEN-1:0]  fill_inst,
    input  logic             deq,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pending
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             do_alloc;
    logic             do_fill;
    logic             do_deq;

    assign do_alloc = alloc && (count_q < FULL);
    assign do_fill  = fill && (pend_q != '0);
    assign do_deq   = deq && entries_q[head_q].filled;

    // Alloc, fill and head always address distinct slots, so the three updates never collide.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        count_d   = count_q;
        pend_d    = pend_q;

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            head_d  = '0;
            alloc_d = '0;
            fill_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            if (do_alloc) begin
                entries_d[alloc_q].pc     = alloc_pc;
                entries_d[alloc_q].inst   = NOP_INST;
                entries_d[alloc_q].filled = 1'b0;
                alloc_d                   = alloc_q + PTR_W'(1);
            end
            if (do_fill) begin
                entries_d[fill_q].inst   = fill_inst;
                entries_d[fill_q].filled = 1'b1;
                fill_d                   = fill_q + PTR_W'(1);
            end
            if (do_deq) begin
                entries_d[head_q].filled = 1'b0;
                head_d                   = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_deq);
            pend_d  = pend_q + CNT_W'(do_alloc) - CNT_W'(do_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            alloc_q <= '0;
            fill_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
        end
    end

    assign head    = entries_q[head_q];
    assign count   = count_q;
    assign pending = pend_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// RV64 fetch stage: PC generation, request throttling against the queue, and redirect flushing
// with a count of stale in-flight responses that must be discarded.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_inst
);

    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam int               SUM_W     = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             started_q, started_d;

    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pending;
    logic [SUM_W-1:0] in_use;
    logic [SUM_W-1:0] outstanding;
    logic             req_fire;
    logic             fill;
    logic             deq;

    // Dropped-but-not-yet-returned requests still occupy memory slots, so they throttle fetch.
    assign in_use         = {1'b0, count} + {1'b0, drop_q};
    assign imem_req_valid = rstn && started_q && !redirect_valid && (in_use < DEPTH_SUM);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fill = !redirect_valid && imem_resp_valid && (drop_q == '0);
    assign deq  = id_valid && id_ready && !redirect_valid;

    always_comb begin
        pc_d        = pc_q;
        drop_d      = drop_q;
        started_d   = 1'b1;
        outstanding = '0;

        if (redirect_valid) begin
            pc_d        = align_word(redirect_pc);
            outstanding = {1'b0, drop_q} + {1'b0, pending};
            if (imem_resp_valid && (outstanding != '0)) begin
                outstanding = outstanding - SUM_W'(1);
            end
            if (outstanding > DEPTH_SUM) begin
                outstanding = DEPTH_SUM;
            end
            drop_d = outstanding[CNT_W-1:0];
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q      <= align_word(RESET_PC);
            drop_q    <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            started_q <= started_d;
        end
    end

    fetch_ring_buf #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect_valid),
        .alloc     (req_fire),
        .alloc_pc  (pc_q),
        .fill      (fill),
        .fill_inst (imem_resp_data),
        .deq       (deq),
        .head      (head),
        .count     (count),
        .pending   (pending)
    );

    assign id_valid = head.filled;
    assign id_pc    = id_valid ? head.pc : '0;
    assign id_inst  = id_valid ? head.inst : NOP_INST;

endmodule
